cpu_control_fsm: RTL and testbench

//  Multicycle control unit for the MPS core: fetches 16-bit words from IMEM into the IR.
//  The IR feeds the instruction decoder; this block sequences decode, data-memory access
//  and register-file writeback from the decoded opcode. It owns the PC and drives every

---
 rtl/cpu_control_fsm.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cpu_control_fsm
//  Purpose  : Multicycle control unit for the MPS core. Fetches 16-bit words
//             from IMEM into the IR, then sequences decode, data-memory access
//             and register-file writeback from the decoded opcode. Owns the PC
//             and drives every datapath enable. One instruction at a time;
//             IMEM and DMEM use req/ack handshakes.
//
//  Parameters:
//    PC_WIDTH   IMEM word-address width (PC wraps modulo 2**PC_WIDTH)
//    IMM_WIDTH  decoded immediate width (branch/jump target source)
//
//  Ports:
//    clk, rst            clock (rising edge), synchronous active-high reset
//    run                 start execution from IDLE
//    imem_addr/req/ack   instruction fetch handshake (addr = PC)
//    ir_we               IR load strobe (FETCH and imem_ack)
//    opcode, imm         decoder fields from the current IR
//    ra_zero             reg_a == 0 (branch condition)
//    alu_op              0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
//    rf_we, rf_wsrc      register write strobe; source 0 ALU, 1 imm, 2 DMEM
//    dmem_req/we/ack     data access handshake (we = store)
//    retired             one-cycle pulse when an instruction completes
//    halted              core stopped in HALT
//    illegal             undefined opcode trapped (sticky until rst)
//
//  Configuration macro:
//    CTRL_ILLEGAL_TRAP_EN  defined: undefined opcode halts and raises
//                          illegal. Undefined: undefined opcode acts as NOP.
//
//  Revision : 1.0  initial release
// ============================================================================
module cpu_control_fsm #(
    parameter int PC_WIDTH  = 8,
    parameter int IMM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic [PC_WIDTH-1:0]  imem_addr,
    output logic                 imem_req,
    input  logic                 imem_ack,
    output logic                 ir_we,
    input  logic [3:0]           opcode,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic                 ra_zero,
    output logic [2:0]           alu_op,
    output logic                 rf_we,
    output logic [1:0]           rf_wsrc,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 retired,
    output logic                 halted,
    output logic                 illegal
);

    // ------------------------------------------------------------------
    // State and opcode encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    localparam logic [3:0] c_OP_NOP = 4'h0;
    localparam logic [3:0] c_OP_LDI = 4'h1;
    localparam logic [3:0] c_OP_ADD = 4'h2;
    localparam logic [3:0] c_OP_SUB = 4'h3;
    localparam logic [3:0] c_OP_AND = 4'h4;
    localparam logic [3:0] c_OP_OR  = 4'h5;
    localparam logic [3:0] c_OP_XOR = 4'h6;
    localparam logic [3:0] c_OP_LD  = 4'h7;
    localparam logic [3:0] c_OP_ST  = 4'h8;
    localparam logic [3:0] c_OP_JMP = 4'h9;
    localparam logic [3:0] c_OP_BZ  = 4'hA;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    localparam logic [1:0] c_WSRC_ALU = 2'd0;
    localparam logic [1:0] c_WSRC_IMM = 2'd1;
    localparam logic [1:0] c_WSRC_MEM = 2'd2;

    localparam logic [PC_WIDTH-1:0] c_PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [2:0]          w_next_state;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_imm_pc;
    logic                w_retire;
    logic                w_trap;

    // PC+1 wraps naturally at all-ones because the sum is PC_WIDTH bits.
    assign w_pc_inc  = r_pc + c_PC_ONE;
    assign imem_addr = r_pc;

    // Jump/branch target: the immediate resized to the PC width.
    generate
        if (IMM_WIDTH >= PC_WIDTH) begin : g_imm_trunc
            assign w_imm_pc = imm[PC_WIDTH-1:0];
            if (IMM_WIDTH > PC_WIDTH) begin : g_imm_drop
                // Upper immediate bits cannot address IMEM; intentionally dropped.
                logic w_imm_hi_unused;
                assign w_imm_hi_unused = ^imm[IMM_WIDTH-1:PC_WIDTH];
            end
        end else begin : g_imm_zext
            assign w_imm_pc = {{(PC_WIDTH-IMM_WIDTH){1'b0}}, imm};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Process 1: state register (plus PC and trap flag)
    // ------------------------------------------------------------------
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_pc      <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state   <= w_next_state;
            r_pc      <= w_next_pc;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal <= r_illegal | w_trap;
`endif
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Process 2: next-state, next-PC and completion decode.
    // The PC only moves on completion, so it is stable across every
    // handshake wait; the IR is only loaded on imem_ack, so opcode stays
    // valid through DECODE, MEM and WB.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_retire     = 1'b0;
        w_trap       = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (run) begin
                    w_next_state = c_ST_FETCH;
                end
            end

            c_ST_FETCH: begin
                if (imem_ack) begin
                    w_next_state = c_ST_DECODE;
                end
            end

            c_ST_DECODE: begin
                case (opcode)
                    c_OP_NOP: begin
                        w_next_state = c_ST_FETCH;
                        w_next_pc    = w_pc_inc;
                        w_retire     = 1'b1;
                    end
                    c_OP_LDI, c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR: begin
                        w_next_state = c_ST_WB;
                    end
                    c_OP_LD, c_OP_ST: begin
                        w_next_state = c_ST_MEM;
                    end
                    c_OP_JMP: begin
                        w_next_state = c_ST_FETCH;
                        w_next_pc    = w_imm_pc;
                        w_retire     = 1'b1;
                    end
                    c_OP_BZ: begin
                        w_next_state = c_ST_FETCH;
                        w_next_pc    = ra_zero ? w_imm_pc : w_pc_inc;
                        w_retire     = 1'b1;
                    end
                    c_OP_HLT: begin
                        w_next_state = c_ST_HALT;
                        w_retire     = 1'b1;
                    end
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        // PC is left pointing at the faulting word.
                        w_next_state = c_ST_HALT;
                        w_trap       = 1'b1;
`else
                        w_next_state = c_ST_FETCH;
                        w_next_pc    = w_pc_inc;
                        w_retire     = 1'b1;
`endif
                    end
                endcase
            end

            c_ST_MEM: begin
                if (dmem_ack) begin
                    if (opcode == c_OP_ST) begin
                        w_next_state = c_ST_FETCH;
                        w_next_pc    = w_pc_inc;
                        w_retire     = 1'b1;
                    end else begin
                        w_next_state = c_ST_WB;
                    end
                end
            end

            c_ST_WB: begin
                w_next_state = c_ST_FETCH;
                w_next_pc    = w_pc_inc;
                w_retire     = 1'b1;
            end

            c_ST_HALT: begin
                w_next_state = c_ST_HALT;
            end

            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: datapath controls, decoded from state. ir_we and retired
    // also look at the handshake/opcode so they land in the completing
    // cycle rather than one cycle late.
    // ------------------------------------------------------------------
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        rf_wsrc  = c_WSRC_ALU;
        alu_op   = 3'd0;
        halted   = 1'b0;
        retired  = w_retire;

        case (r_state)
            c_ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            c_ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == c_OP_ST);
            end
            c_ST_WB: begin
                rf_we = 1'b1;
                if (opcode == c_OP_LDI) begin
                    rf_wsrc = c_WSRC_IMM;
                end else if (opcode == c_OP_LD) begin
                    rf_wsrc = c_WSRC_MEM;
                end else begin
                    rf_wsrc = c_WSRC_ALU;
                end
                // ALU opcodes 2..6 map directly onto alu_op 0..4.
                if (opcode >= c_OP_ADD && opcode <= c_OP_XOR) begin
                    alu_op = opcode[2:0] - 3'd2;
                end
            end
            c_ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_control_fsm
//  Purpose  : Self-checking bench for cpu_control_fsm. An IMEM/IR model hands
//             out instruction words in program order, acknowledge responders
//             insert per-instruction wait states, and a monitor compares a
//             snapshot of the controls against a queue of expected events.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] imem_addr;
    logic       imem_req, imem_ack, ir_we;
    logic [3:0] opcode;
    logic [7:0] imm;
    logic       ra_zero;
    logic [2:0] alu_op;
    logic       rf_we;
    logic [1:0] rf_wsrc;
    logic       dmem_req, dmem_we, dmem_ack;
    logic       retired, halted, illegal;

    always #5 clk = ~clk;

    cpu_control_fsm #(.PC_WIDTH(8), .IMM_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .ir_we(ir_we), .opcode(opcode), .imm(imm), .ra_zero(ra_zero),
        .alu_op(alu_op), .rf_we(rf_we), .rf_wsrc(rf_wsrc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .retired(retired), .halted(halted), .illegal(illegal)
    );

    // ---------------- program / IR model (indexed by fetch order) -------
    logic [15:0] prog [256];
    int          idly [256];
    int          ddly [256];
    logic        rz   [256];
    logic [15:0] ir      = 16'h0000;
    logic        rz_cur  = 1'b0;
    int          fetch_n = 0;

    assign opcode  = ir[3:0];
    assign imm     = ir[15:8];
    assign ra_zero = rz_cur;

    always @(posedge clk) begin
        if (rst) begin
            fetch_n <= 0;
        end else if (ir_we) begin
            ir      <= prog[fetch_n];
            rz_cur  <= rz[fetch_n];
            fetch_n <= fetch_n + 1;
        end
    end

    // ---------------- acknowledge responders ----------------------------
    logic iack_auto = 1'b0, dack_auto = 1'b0;
    logic iack_force = 1'b0, dack_force = 1'b0;
    assign imem_ack = iack_auto | iack_force;
    assign dmem_ack = dack_auto | dack_force;

    initial begin
        int icnt, dcnt;
        icnt = 0;
        dcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req) begin
                iack_auto = (icnt >= idly[fetch_n]);
                icnt++;
            end else begin
                iack_auto = 1'b0;
                icnt = 0;
            end
            if (dmem_req) begin
                dack_auto = (dcnt >= ddly[(fetch_n > 0) ? fetch_n - 1 : 0]);
                dcnt++;
            end else begin
                dack_auto = 1'b0;
                dcnt = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------------------------------
    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic [7:0] addr;
        logic       dmem_req;
        logic       dmem_we;
        logic       rf_we;
        logic [1:0] rf_wsrc;
        logic [2:0] alu_op;
        logic       retired;
        logic       halted;
        logic       illegal;
        logic [7:0] req_len;
    } snap_t;

    typedef struct {
        string name;
        snap_t s;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic probe    = 1'b0;

    function automatic snap_t S(logic ireq, logic irw, logic [7:0] a, logic dreq,
                                logic dwe, logic rfw, logic [1:0] ws, logic [2:0] alu,
                                logic ret, logic hlt, logic ill, logic [7:0] len);
        snap_t s;
        s.imem_req = ireq; s.ir_we = irw; s.addr = a; s.dmem_req = dreq;
        s.dmem_we = dwe; s.rf_we = rfw; s.rf_wsrc = ws; s.alu_op = alu;
        s.retired = ret; s.halted = hlt; s.illegal = ill; s.req_len = len;
        return s;
    endfunction

    function automatic void push(string n, snap_t s);
        exp_t e;
        e.name = n;
        e.s    = s;
        q.push_back(e);
    endfunction

    // fetch accepted / decode retire / writeback / memory completion / halt
    function automatic void pF(string n, logic [7:0] a, logic [7:0] len);
        push(n, S(1, 1, a, 0, 0, 0, 2'd0, 3'd0, 0, 0, 0, len));
    endfunction
    function automatic void pR(string n, logic [7:0] a);
        push(n, S(0, 0, a, 0, 0, 0, 2'd0, 3'd0, 1, 0, 0, 8'd0));
    endfunction
    function automatic void pW(string n, logic [7:0] a, logic [1:0] ws, logic [2:0] alu);
        push(n, S(0, 0, a, 0, 0, 1, ws, alu, 1, 0, 0, 8'd0));
    endfunction
    function automatic void pM(string n, logic [7:0] a, logic we, logic [7:0] len, logic ret);
        push(n, S(0, 0, a, 1, we, 0, 2'd0, 3'd0, ret, 0, 0, len));
    endfunction
    function automatic snap_t H(logic [7:0] a, logic ill);
        return S(0, 0, a, 0, 0, 0, 2'd0, 3'd0, 0, 1, ill, 8'd0);
    endfunction
    function automatic snap_t Z(logic [7:0] a);
        return S(0, 0, a, 0, 0, 0, 2'd0, 3'd0, 0, 0, 0, 8'd0);
    endfunction

    // Monitor: a snapshot is taken whenever the DUT shows an event of
    // interest (or the stimulus asks for a probe) and matched in order.
    initial begin
        int    ilen, dlen;
        snap_t got;
        exp_t  e;
        ilen = 0;
        dlen = 0;
        forever begin
            @(negedge clk);
            ilen = imem_req ? ilen + 1 : 0;
            dlen = dmem_req ? dlen + 1 : 0;
            if (ir_we || rf_we || retired || (dmem_req && dmem_ack) || probe) begin
                got = S(imem_req, ir_we, imem_addr, dmem_req, dmem_we, rf_we, rf_wsrc,
                        alu_op, retired, halted, illegal,
                        imem_req ? 8'(ilen) : (dmem_req ? 8'(dlen) : 8'd0));
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_event: got %h required none", got);
                end else begin
                    e = q.pop_front();
                    if (got === e.s) n_pass++;
                    else $display("FAIL %s: got %h required %h", e.name, got, e.s);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------------------------
    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            prog[i] = 16'h000F;
            idly[i] = 0;
            ddly[i] = 0;
            rz[i]   = 1'b0;
        end
    endtask

    task automatic do_reset(string n);
        @(posedge clk);
        #1 rst = 1'b1;
        run = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        push(n, Z(8'h00));
        probe = 1'b1;
        @(negedge clk);
        #1 probe = 1'b0;
    endtask

    task automatic go();
        @(posedge clk);
        #1 run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
    endtask

    task automatic drain(string n, int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL %s: %0d events pending after %0d cycles, required 0", n, q.size(), budget);
            q.delete();
        end
    endtask

    task automatic probe_chk(string n, snap_t s);
        @(posedge clk);
        #1;
        push(n, s);
        probe = 1'b1;
        @(negedge clk);
        #1 probe = 1'b0;
    endtask

    // ---------------- watchdog ------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios --------------------------------
    initial begin
        // LDI r1,5 ; ADD ; HLT with zero-wait acks
        clear_prog();
        prog[0] = 16'h0501; prog[1] = 16'h0002; prog[2] = 16'h000F;
        do_reset("reset_state");
        pF("s1_fetch0", 8'h00, 8'd1); pW("s1_ldi_wb", 8'h00, 2'd1, 3'd0);
        pF("s1_fetch1", 8'h01, 8'd1); pW("s1_add_wb", 8'h01, 2'd0, 3'd0);
        pF("s1_fetch2", 8'h02, 8'd1); pR("s1_hlt_retire", 8'h02);
        go();
        drain("s1_drain", 60);
        probe_chk("s1_halted", H(8'h02, 1'b0));

        // first fetch acknowledged after 3 wait cycles
        clear_prog();
        prog[0] = 16'h0000; idly[0] = 3; prog[1] = 16'h000F;
        do_reset("s2_reset");
        pF("s2_slow_fetch", 8'h00, 8'd4); pR("s2_nop_retire", 8'h00);
        pF("s2_fetch1", 8'h01, 8'd1);     pR("s2_hlt_retire", 8'h01);
        go();
        drain("s2_drain", 60);
        probe_chk("s2_halted", H(8'h01, 1'b0));

        // LD (2 wait cycles), ST, AND, XOR, HLT
        clear_prog();
        prog[0] = 16'h0007; ddly[0] = 2; prog[1] = 16'h0008;
        prog[2] = 16'h0004; prog[3] = 16'h0006; prog[4] = 16'h000F;
        do_reset("s3_reset");
        pF("s3_fetch0", 8'h00, 8'd1); pM("s3_ld_mem", 8'h00, 1'b0, 8'd3, 1'b0);
        pW("s3_ld_wb", 8'h00, 2'd2, 3'd0);
        pF("s3_fetch1", 8'h01, 8'd1); pM("s3_st_mem", 8'h01, 1'b1, 8'd1, 1'b1);
        pF("s3_fetch2", 8'h02, 8'd1); pW("s3_and_wb", 8'h02, 2'd0, 3'd2);
        pF("s3_fetch3", 8'h03, 8'd1); pW("s3_xor_wb", 8'h03, 2'd0, 3'd4);
        pF("s3_fetch4", 8'h04, 8'd1); pR("s3_hlt_retire", 8'h04);
        go();
        drain("s3_drain", 80);
        probe_chk("s3_halted", H(8'h04, 1'b0));

        // BZ taken/not taken, JMP from 0xFF, NOP wrap at 0xFF
        clear_prog();
        prog[0] = 16'h200A; rz[0] = 1'b1;
        prog[1] = 16'h400A; rz[1] = 1'b0;
        prog[2] = 16'hFF09; prog[3] = 16'h3009; prog[4] = 16'hFF09;
        prog[5] = 16'h0000; prog[6] = 16'h000F;
        do_reset("s4_reset");
        pF("s4_fetch_00", 8'h00, 8'd1); pR("s4_bz_taken", 8'h00);
        pF("s4_fetch_20", 8'h20, 8'd1); pR("s4_bz_not_taken", 8'h20);
        pF("s4_fetch_21", 8'h21, 8'd1); pR("s4_jmp_ff", 8'h21);
        pF("s4_fetch_ff", 8'hFF, 8'd1); pR("s4_jmp_from_ff", 8'hFF);
        pF("s4_fetch_30", 8'h30, 8'd1); pR("s4_jmp_ff_again", 8'h30);
        pF("s4_fetch_ff2", 8'hFF, 8'd1); pR("s4_nop_at_ff", 8'hFF);
        pF("s4_fetch_wrap", 8'h00, 8'd1); pR("s4_hlt_retire", 8'h00);
        go();
        drain("s4_drain", 100);
        probe_chk("s4_halted", H(8'h00, 1'b0));

        // reset while a data access is stalled; late acks must be ignored
        clear_prog();
        prog[0] = 16'h0007; ddly[0] = 1000;
        do_reset("s5_reset");
        pF("s5_fetch0", 8'h00, 8'd1);
        go();
        drain("s5_drain_a", 40);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        push("s5_reset_mid_mem", Z(8'h00));
        probe = 1'b1;
        @(negedge clk);
        #1 probe = 1'b0;
        iack_force = 1'b1;
        dack_force = 1'b1;
        repeat (3) @(posedge clk);
        #1 iack_force = 1'b0;
        dack_force = 1'b0;
        probe_chk("s5_idle_after_late_ack", Z(8'h00));
        prog[0] = 16'h000F;
        pF("s5_restart_fetch0", 8'h00, 8'd1); pR("s5_hlt_retire", 8'h00);
        go();
        drain("s5_drain_b", 40);
        probe_chk("s5_halted", H(8'h00, 1'b0));

        // undefined opcode 0xB
        clear_prog();
        prog[0] = 16'h000B; prog[1] = 16'h000F;
        do_reset("s6_reset");
`ifdef CTRL_ILLEGAL_TRAP_EN
        pF("s6_fetch0", 8'h00, 8'd1);
        go();
        drain("s6_drain", 40);
        probe_chk("s6_trap_halted", H(8'h00, 1'b1));
`else
        pF("s6_fetch0", 8'h00, 8'd1); pR("s6_undef_as_nop", 8'h00);
        pF("s6_fetch1", 8'h01, 8'd1); pR("s6_hlt_retire", 8'h01);
        go();
        drain("s6_drain", 40);
        probe_chk("s6_halted", H(8'h01, 1'b0));
`endif
        do_reset("s6_reset_clears");
        drain("final_drain", 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
